// File: rtl/alu_unit.sv
// alu_unit: integer execute stage driving the registered ALU result bus.
// Define ALU_MUL_EN to add the iterative MUL/MULHU unit with busy backpressure.
module alu_unit #(
  parameter int ROB_W = 5,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             wrong_commit,
  input  logic [6:0]       alu_op,
  input  logic [XLEN-1:0]  Vi_alu,
  input  logic [XLEN-1:0]  Vj_alu,
  input  logic [XLEN-1:0]  imm_alu,
  input  logic [XLEN-1:0]  pc_alu,
  input  logic [ROB_W-1:0] rob_id_in,
  output logic             alu_valid,
  output logic [XLEN-1:0]  alu_res,
  output logic [ROB_W-1:0] alu_rob_id,
  output logic             alu_jump,
  output logic [XLEN-1:0]  alu_target,
  output logic             alu_busy
);

  localparam logic [6:0] OP_LUI   = 7'd1;
  localparam logic [6:0] OP_AUIPC = 7'd2;
  localparam logic [6:0] OP_JAL   = 7'd3;
  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BNE   = 7'd6;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BGE   = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_ADD   = 7'd11;
  localparam logic [6:0] OP_SUB   = 7'd12;
  localparam logic [6:0] OP_AND   = 7'd13;
  localparam logic [6:0] OP_OR    = 7'd14;
  localparam logic [6:0] OP_XOR   = 7'd15;
  localparam logic [6:0] OP_SLL   = 7'd16;
  localparam logic [6:0] OP_SRL   = 7'd17;
  localparam logic [6:0] OP_SRA   = 7'd18;
  localparam logic [6:0] OP_SLT   = 7'd19;
  localparam logic [6:0] OP_SLTU  = 7'd20;
  localparam logic [6:0] OP_ADDI  = 7'd21;
  localparam logic [6:0] OP_ANDI  = 7'd22;
  localparam logic [6:0] OP_ORI   = 7'd23;
  localparam logic [6:0] OP_XORI  = 7'd24;
  localparam logic [6:0] OP_SLLI  = 7'd25;
  localparam logic [6:0] OP_SRLI  = 7'd26;
  localparam logic [6:0] OP_SRAI  = 7'd27;
  localparam logic [6:0] OP_SLTI  = 7'd28;
  localparam logic [6:0] OP_SLTIU = 7'd29;
  localparam logic [6:0] OP_MUL   = 7'd30;
  localparam logic [6:0] OP_MULHU = 7'd31;

  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] ex_res;
  logic [XLEN-1:0] ex_tgt;
  logic            ex_jump;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_tgt;
  logic            is_br;
  logic            taken;
  logic [4:0]      shj;
  logic [4:0]      shi;

  assign shj = Vj_alu[4:0];
  assign shi = imm_alu[4:0];

  always_comb begin : exec
    ex_res  = '0;
    ex_tgt  = '0;
    ex_jump = 1'b0;
    is_br   = 1'b0;
    taken   = 1'b0;
    pc4     = pc_alu + FOUR;
    br_tgt  = pc_alu + imm_alu;
    case (alu_op)
      OP_LUI:   ex_res = imm_alu;
      OP_AUIPC: ex_res = br_tgt;
      OP_JAL: begin
        ex_res  = pc4;
        ex_jump = 1'b1;
        ex_tgt  = br_tgt;
      end
      OP_JALR: begin
        ex_res  = pc4;
        ex_jump = 1'b1;
        ex_tgt  = (Vi_alu + imm_alu) & ~ONE;
      end
      OP_BEQ: begin
        is_br = 1'b1;
        taken = Vi_alu == Vj_alu;
      end
      OP_BNE: begin
        is_br = 1'b1;
        taken = Vi_alu != Vj_alu;
      end
      OP_BLT: begin
        is_br = 1'b1;
        taken = $signed(Vi_alu) < $signed(Vj_alu);
      end
      OP_BGE: begin
        is_br = 1'b1;
        taken = $signed(Vi_alu) >= $signed(Vj_alu);
      end
      OP_BLTU: begin
        is_br = 1'b1;
        taken = Vi_alu < Vj_alu;
      end
      OP_BGEU: begin
        is_br = 1'b1;
        taken = Vi_alu >= Vj_alu;
      end
      OP_ADD:   ex_res = Vi_alu + Vj_alu;
      OP_SUB:   ex_res = Vi_alu - Vj_alu;
      OP_AND:   ex_res = Vi_alu & Vj_alu;
      OP_OR:    ex_res = Vi_alu | Vj_alu;
      OP_XOR:   ex_res = Vi_alu ^ Vj_alu;
      OP_SLL:   ex_res = Vi_alu << shj;
      OP_SRL:   ex_res = Vi_alu >> shj;
      OP_SRA:   ex_res = $signed(Vi_alu) >>> shj;
      OP_SLT:
        ex_res = {{(XLEN-1){1'b0}},
                  $signed(Vi_alu) < $signed(Vj_alu)};
      OP_SLTU:
        ex_res = {{(XLEN-1){1'b0}}, Vi_alu < Vj_alu};
      OP_ADDI:  ex_res = Vi_alu + imm_alu;
      OP_ANDI:  ex_res = Vi_alu & imm_alu;
      OP_ORI:   ex_res = Vi_alu | imm_alu;
      OP_XORI:  ex_res = Vi_alu ^ imm_alu;
      OP_SLLI:  ex_res = Vi_alu << shi;
      OP_SRLI:  ex_res = Vi_alu >> shi;
      OP_SRAI:  ex_res = $signed(Vi_alu) >>> shi;
      OP_SLTI:
        ex_res = {{(XLEN-1){1'b0}},
                  $signed(Vi_alu) < $signed(imm_alu)};
      OP_SLTIU:
        ex_res = {{(XLEN-1){1'b0}}, Vi_alu < imm_alu};
      default:  ex_res = '0;
    endcase
    if (is_br) begin
      ex_res  = {{(XLEN-1){1'b0}}, taken};
      ex_jump = taken;
      ex_tgt  = taken ? br_tgt : pc4;
    end
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              hi_q, hi_d;
  logic [ROB_W-1:0]  mrob_q, mrob_d;
  logic              busy_q, busy_d;
  logic              is_mul;

  assign is_mul   = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
  assign alu_busy = busy_q;

  always_comb begin : mul_next
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    mrob_d   = mrob_q;
    busy_d   = busy_q;
    if (wrong_commit) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (rdy) begin
      // busy lags the FSM by one edge and drops as the result is driven
      busy_d = (state_q == S_MUL);
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, Vi_alu};
            mplier_d = Vj_alu;
            cnt_d    = '0;
            hi_d     = (alu_op == OP_MULHU);
            mrob_d   = rob_id_in;
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      mrob_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      mrob_q   <= mrob_d;
      busy_q   <= busy_d;
    end
  end

  a_no_issue_busy: assert property (
    @(posedge clk) disable iff (rst)
    !(rdy && !wrong_commit &&
      state_q != S_IDLE && alu_op != '0))
    else $error("alu_unit: op dropped, multiplier busy");
`else
  assign alu_busy = 1'b0;
`endif

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic             jump_q, jump_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;

  always_comb begin : out_next
    valid_d = valid_q;
    res_d   = res_q;
    rob_d   = rob_q;
    jump_d  = jump_q;
    tgt_d   = tgt_q;
    if (wrong_commit) begin
      valid_d = 1'b0;
      res_d   = '0;
      rob_d   = '0;
      jump_d  = 1'b0;
      tgt_d   = '0;
    end else if (rdy) begin
      valid_d = 1'b0;
      res_d   = '0;
      rob_d   = '0;
      jump_d  = 1'b0;
      tgt_d   = '0;
`ifdef ALU_MUL_EN
      if (state_q == S_DONE) begin
        valid_d = 1'b1;
        res_d   = hi_q ? acc_q[2*XLEN-1:XLEN]
                       : acc_q[XLEN-1:0];
        rob_d   = mrob_q;
      end else if (state_q == S_IDLE &&
                   alu_op != '0 && !is_mul) begin
        valid_d = 1'b1;
        res_d   = ex_res;
        rob_d   = rob_id_in;
        jump_d  = ex_jump;
        tgt_d   = ex_tgt;
      end
`else
      if (alu_op != '0) begin
        valid_d = 1'b1;
        res_d   = ex_res;
        rob_d   = rob_id_in;
        jump_d  = ex_jump;
        tgt_d   = ex_tgt;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      rob_q   <= '0;
      jump_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      rob_q   <= rob_d;
      jump_q  <= jump_d;
      tgt_q   <= tgt_d;
    end
  end

  assign alu_valid  = valid_q;
  assign alu_res    = res_q;
  assign alu_rob_id = rob_q;
  assign alu_jump   = jump_q;
  assign alu_target = tgt_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results for alu_unit.
// Multiplier vectors compile in only with ALU_MUL_EN.
module tb_alu_unit;

  localparam logic [6:0] OP_LUI   = 7'd1;
  localparam logic [6:0] OP_AUIPC = 7'd2;
  localparam logic [6:0] OP_JAL   = 7'd3;
  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_ADD   = 7'd11;
  localparam logic [6:0] OP_SUB   = 7'd12;
  localparam logic [6:0] OP_OR    = 7'd14;
  localparam logic [6:0] OP_SRA   = 7'd18;
  localparam logic [6:0] OP_SLT   = 7'd19;
  localparam logic [6:0] OP_SLTU  = 7'd20;
  localparam logic [6:0] OP_XORI  = 7'd24;
  localparam logic [6:0] OP_SLLI  = 7'd25;
  localparam logic [6:0] OP_MUL   = 7'd30;
  localparam logic [6:0] OP_MULHU = 7'd31;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        wrong_commit = 1'b0;
  logic [6:0]  alu_op = '0;
  logic [31:0] Vi_alu = '0;
  logic [31:0] Vj_alu = '0;
  logic [31:0] imm_alu = '0;
  logic [31:0] pc_alu = '0;
  logic [4:0]  rob_id_in = '0;
  logic        alu_valid;
  logic [31:0] alu_res;
  logic [4:0]  alu_rob_id;
  logic        alu_jump;
  logic [31:0] alu_target;
  logic        alu_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_unit #(.ROB_W(5), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .wrong_commit (wrong_commit),
    .alu_op       (alu_op),
    .Vi_alu       (Vi_alu),
    .Vj_alu       (Vj_alu),
    .imm_alu      (imm_alu),
    .pc_alu       (pc_alu),
    .rob_id_in    (rob_id_in),
    .alu_valid    (alu_valid),
    .alu_res      (alu_res),
    .alu_rob_id   (alu_rob_id),
    .alu_jump     (alu_jump),
    .alu_target   (alu_target),
    .alu_busy     (alu_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [31:0] r,
                         input logic [4:0] id,
                         input logic j,
                         input logic [31:0] t);
    chk({tag, ".valid"}, {31'b0, alu_valid}, {31'b0, v});
    chk({tag, ".res"}, alu_res, r);
    chk({tag, ".rob"}, {27'b0, alu_rob_id}, {27'b0, id});
    chk({tag, ".jump"}, {31'b0, alu_jump}, {31'b0, j});
    chk({tag, ".target"}, alu_target, t);
  endtask

  task automatic drive(input logic [6:0] op,
                       input logic [31:0] vi,
                       input logic [31:0] vj,
                       input logic [31:0] imm,
                       input logic [31:0] pc,
                       input logic [4:0] rob);
    @(negedge clk);
    alu_op    = op;
    Vi_alu    = vi;
    Vj_alu    = vj;
    imm_alu   = imm;
    pc_alu    = pc;
    rob_id_in = rob;
  endtask

  task automatic issue(input logic [6:0] op,
                       input logic [31:0] vi,
                       input logic [31:0] vj,
                       input logic [31:0] imm,
                       input logic [31:0] pc,
                       input logic [4:0] rob);
    drive(op, vi, vj, imm, pc, rob);
    @(posedge clk);
    #1;
    alu_op = '0;
  endtask

  initial begin
    int pulses;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("reset.busy", {31'b0, alu_busy}, 32'h0);
    @(negedge clk) rst = 1'b0;

    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 5'd3);
    chk_out("add", 1'b1, 32'h80000000, 5'd3, 1'b0, 32'h0);
    issue(OP_BLT, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 5'd4);
    chk_out("blt", 1'b1, 32'h1, 5'd4, 1'b1, 32'h120);
    issue(OP_BLTU, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 5'd5);
    chk_out("bltu", 1'b1, 32'h0, 5'd5, 1'b0, 32'h104);
    issue(OP_JALR, 32'h1003, 32'h0, 32'h4, 32'h40, 5'd6);
    chk_out("jalr", 1'b1, 32'h44, 5'd6, 1'b1, 32'h1006);
    issue(OP_SRA, 32'h80000000, 32'h21, 32'h0, 32'h0, 5'd7);
    chk_out("sra", 1'b1, 32'hC0000000, 5'd7, 1'b0, 32'h0);
    issue(OP_SUB, 32'h5, 32'h7, 32'h0, 32'h0, 5'd8);
    chk_out("sub", 1'b1, 32'hFFFFFFFE, 5'd8, 1'b0, 32'h0);
    issue(OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd9);
    chk_out("slt", 1'b1, 32'h1, 5'd9, 1'b0, 32'h0);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd10);
    chk_out("sltu", 1'b1, 32'h0, 5'd10, 1'b0, 32'h0);
    issue(OP_SLLI, 32'h1, 32'h0, 32'h25, 32'h0, 5'd11);
    chk_out("slli", 1'b1, 32'h20, 5'd11, 1'b0, 32'h0);
    issue(OP_LUI, 32'h0, 32'h0, 32'h12345000, 32'h0, 5'd12);
    chk_out("lui", 1'b1, 32'h12345000, 5'd12, 1'b0, 32'h0);
    issue(OP_AUIPC, 32'h0, 32'h0, 32'h2000, 32'h1000, 5'd13);
    chk_out("auipc", 1'b1, 32'h3000, 5'd13, 1'b0, 32'h0);
    issue(OP_JAL, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h200, 5'd14);
    chk_out("jal", 1'b1, 32'h204, 5'd14, 1'b1, 32'h1F0);
    issue(OP_BEQ, 32'h1, 32'h2, 32'h8, 32'h300, 5'd15);
    chk_out("beq", 1'b1, 32'h0, 5'd15, 1'b0, 32'h304);
    issue(OP_XORI, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 32'h0, 5'd16);
    chk_out("xori", 1'b1, 32'hF00FF00F, 5'd16, 1'b0, 32'h0);
    issue(7'd100, 32'h5, 32'h6, 32'h7, 32'h8, 5'd9);
    chk_out("unknown", 1'b1, 32'h0, 5'd9, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("bubble", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

`ifndef ALU_MUL_EN
    issue(OP_MUL, 32'h3, 32'h5, 32'h0, 32'h0, 5'd6);
    chk_out("mul_unk", 1'b1, 32'h0, 5'd6, 1'b0, 32'h0);
    chk("mul_unk.busy", {31'b0, alu_busy}, 32'h0);
    issue(OP_MULHU, 32'h3, 32'h5, 32'h0, 32'h0, 5'd7);
    chk_out("mulhu_unk", 1'b1, 32'h0, 5'd7, 1'b0, 32'h0);
`endif

    // stall: ADD, SUB, then OR held off by two rdy=0 cycles
    issue(OP_ADD, 32'h10, 32'h20, 32'h0, 32'h0, 5'd1);
    chk_out("stall.add", 1'b1, 32'h30, 5'd1, 1'b0, 32'h0);
    issue(OP_SUB, 32'h10, 32'h4, 32'h0, 32'h0, 5'd2);
    chk_out("stall.sub", 1'b1, 32'hC, 5'd2, 1'b0, 32'h0);
    drive(OP_OR, 32'hF0, 32'h0F, 32'h0, 32'h0, 5'd3);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_out("stall.hold", 1'b1, 32'hC, 5'd2, 1'b0, 32'h0);
    end
    @(negedge clk) rdy = 1'b1;
    @(posedge clk);
    #1;
    alu_op = '0;
    chk_out("stall.or", 1'b1, 32'hFF, 5'd3, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("stall.end", {31'b0, alu_valid}, 32'h0);

    // flush discards the op issued alongside it
    issue(OP_JAL, 32'h0, 32'h0, 32'h8, 32'h10, 5'd5);
    drive(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd4);
    wrong_commit = 1'b1;
    @(posedge clk);
    #1;
    alu_op = '0;
    wrong_commit = 1'b0;
    chk_out("flush", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    // flush wins over rdy=0
    issue(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd4);
    drive(OP_ADD, 32'h3, 32'h4, 32'h0, 32'h0, 5'd5);
    rdy = 1'b0;
    wrong_commit = 1'b1;
    @(posedge clk);
    #1;
    alu_op = '0;
    wrong_commit = 1'b0;
    chk_out("flush_nrdy", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk) rdy = 1'b1;

    // asynchronous reset mid-cycle
    issue(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd5);
    chk_out("pre_rst", 1'b1, 32'h3, 5'd5, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk) rst = 1'b0;

`ifdef ALU_MUL_EN
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd7);
    chk("mulhu.busy0", {31'b0, alu_busy}, 32'h0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk("mulhu.busy", {31'b0, alu_busy}, 32'h1);
      chk("mulhu.idle", {31'b0, alu_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    chk_out("mulhu", 1'b1, 32'hFFFFFFFE, 5'd7, 1'b0, 32'h0);
    chk("mulhu.busy33", {31'b0, alu_busy}, 32'h0);
    @(posedge clk);
    #1;
    chk("mulhu.end", {31'b0, alu_valid}, 32'h0);

    issue(OP_MUL, 32'h00012345, 32'h00010000, 32'h0, 32'h0, 5'd8);
    repeat (33) @(posedge clk);
    #1;
    chk_out("mul", 1'b1, 32'h23450000, 5'd8, 1'b0, 32'h0);

    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd9);
    repeat (9) @(posedge clk);
    @(negedge clk) wrong_commit = 1'b1;
    @(posedge clk);
    #1;
    wrong_commit = 1'b0;
    chk("mulflush.busy", {31'b0, alu_busy}, 32'h0);
    chk("mulflush.valid", {31'b0, alu_valid}, 32'h0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (alu_valid) pulses++;
    end
    chk("mulflush.noresult", pulses, 32'h0);
    issue(OP_ADD, 32'h2, 32'h2, 32'h0, 32'h0, 5'd10);
    chk_out("mulflush.add", 1'b1, 32'h4, 5'd10, 1'b0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
